// File: rtl/fxp8s_pkg.sv
// Shared fxp8s definitions: Q4.3 signed fixed-point format and drain FSM states.
// Latency: n/a. Backpressure: n/a.
package fxp8s_pkg;

  localparam int FXP8S_WIDTH   = 8;
  localparam int FXP8S_SIGN    = 7;
  localparam int FXP8S_LSB_POW = -3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2
  } drain_state_t;

endpackage

// File: rtl/fxp8s_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: pushes while full and pops while empty are dropped.
module fxp8s_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_vld,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic                     head_vld,
  output logic [WIDTH-1:0]         head_dat,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign head_vld = (count != '0);
  assign head_dat = mem[rd_ptr];
  assign do_push  = push_vld && (count != (AW+1)'(DEPTH));
  assign do_pop   = pop && head_vld;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/fxp8s_acc_drain.sv
// Drains a row of PE accumulators off a shared bus, in index order, into a valid/ready stream.
// Latency: a PE value appears on out_* the cycle after its read cycle; done 1 cycle after last read.
// Backpressure: a full capture FIFO stops PE enables and holds the index until space frees up.
module fxp8s_acc_drain
  import fxp8s_pkg::*;
#(
  parameter int N_PE       = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int IDX_W      = $clog2(N_PE)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   acc_clr,
  output logic [N_PE-1:0]        pe_en_out,
  input  logic [FXP8S_WIDTH-1:0] pe_bus,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [FXP8S_WIDTH-1:0] out_data,
  output logic [IDX_W-1:0]       out_idx,
  output logic                   out_last
);

  localparam int EW = IDX_W + FXP8S_WIDTH + 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  drain_state_t      state;
  drain_state_t      state_nxt;
  logic [IDX_W-1:0]  idx;
  logic [CW-1:0]     fifo_cnt;
  logic              rd_cyc;
  logic              at_last;
  logic              pop;
  logic [EW-1:0]     push_dat;
  logic [EW-1:0]     head_dat;

  assign at_last = (idx == IDX_W'(N_PE - 1));
  // Enables depend only on registered state so out_ready never reaches the PE row.
  assign rd_cyc    = (state == DRAIN) && (fifo_cnt < CW'(FIFO_DEPTH));
  assign pe_en_out = rd_cyc ? (N_PE'(1) << idx) : '0;
  assign push_dat  = {idx, pe_bus, at_last};
  assign pop       = out_valid && out_ready;

  assign {out_idx, out_data, out_last} = head_dat;
  assign busy    = (state != IDLE);
  assign acc_clr = done;

  fxp8s_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_vld (rd_cyc),
    .push_dat (push_dat),
    .pop      (pop),
    .head_vld (out_valid),
    .head_dat (head_dat),
    .count    (fifo_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = DRAIN;
      DRAIN: if (rd_cyc && at_last) state_nxt = FLUSH;
      FLUSH: begin
        if (pop && (fifo_cnt == CW'(1))) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Index parks on N_PE-1 through FLUSH and only rewinds on the way back to IDLE.
  always_ff @(posedge clk) begin
    if (rst)                       idx <= '0;
    else if (state_nxt == IDLE)    idx <= '0;
    else if (rd_cyc && !at_last)   idx <= idx + 1'b1;
  end

endmodule

// File: tb/tb_fxp8s_acc_drain.sv
// Scoreboard bench: expected entries queued at start, monitor compares on every output handshake.
module tb_fxp8s_acc_drain;

  localparam int N_PE       = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int IDX_W      = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             busy;
  logic             done;
  logic             acc_clr;
  logic [N_PE-1:0]  pe_en_out;
  logic [7:0]       pe_bus;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_data;
  logic [IDX_W-1:0] out_idx;
  logic             out_last;

  fxp8s_acc_drain #(
    .N_PE       (N_PE),
    .FIFO_DEPTH (FIFO_DEPTH),
    .IDX_W      (IDX_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .acc_clr   (acc_clr),
    .pe_en_out (pe_en_out),
    .pe_bus    (pe_bus),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         idx;
    logic [7:0] dat;
    logic       last;
  } exp_t;

  exp_t       q[$];
  logic [7:0] pe_vals [N_PE];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rd_next = 0;
  int rd_cycles = 0;
  int accepted = 0;
  int done_cnt = 0;
  int start_cyc = 0;
  int done_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // PE row model: the enabled PE drives its value, otherwise the bus floats to junk.
  always_comb begin
    pe_bus = 8'hA5;
    for (int k = 0; k < N_PE; k++)
      if (pe_en_out[k]) pe_bus = pe_vals[k];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic issue_start();
    for (int k = 0; k < N_PE; k++) q.push_back('{k, pe_vals[k], k == N_PE - 1});
    rd_next   = 0;
    rd_cycles = 0;
    accepted++;
    start_cyc = cyc;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget, input bit rnd);
    for (int i = 0; i < budget && done_cnt < target; i++) begin
      @(posedge clk); #1;
      if (rnd) out_ready = 1'($urandom_range(0, 1));
    end
    chk("drain_done", done_cnt >= target, 1);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      exp_t e;
      chk("onehot", $countones(pe_en_out) <= 1, 1);
      chk("acc_clr_eq_done", acc_clr, done);
      if (pe_en_out != '0) begin
        chk("read_order", pe_en_out, 32'(1) << rd_next);
        rd_next++;
        rd_cycles++;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("out_unexpected", q.size(), 1);
        end else begin
          e = q.pop_front();
          chk("out_idx", out_idx, e.idx);
          chk("out_data", out_data, e.dat);
          chk("out_last", out_last, e.last);
          chk("done", done, e.last && q.size() == 0);
          if (done) begin
            done_cnt++;
            done_cyc = cyc;
          end
        end
      end else begin
        chk("done_without_pop", done, 0);
      end
    end
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    out_ready = 1'b0;
    for (int k = 0; k < N_PE; k++) pe_vals[k] = 8'h00;
    @(posedge clk); #1;
    chk("rst_busy", busy, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_pe_en", pe_en_out, 0);
    chk("rst_done", done, 0);
    chk("rst_acc_clr", acc_clr, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Plain drain with an always-ready consumer.
    for (int k = 0; k < N_PE; k++) pe_vals[k] = 8'h10 + 8'(k);
    out_ready = 1'b1;
    issue_start();
    wait_done(accepted, 50, 0);
    chk("t1_latency", done_cyc - start_cyc, 9);

    // Stalled consumer: the FIFO fills after exactly FIFO_DEPTH reads.
    out_ready = 1'b0;
    issue_start();
    repeat (12) @(posedge clk);
    #1;
    chk("t2_reads_stalled", rd_cycles, FIFO_DEPTH);
    chk("t2_pe_en_idle", pe_en_out, 0);
    chk("t2_busy", busy, 1);
    out_ready = 1'b1;
    wait_done(accepted, 50, 0);
    chk("t2_reads_total", rd_cycles, N_PE);

    // Corner data values.
    pe_vals[0] = 8'h80; pe_vals[1] = 8'h7F; pe_vals[2] = 8'hFF; pe_vals[3] = 8'h00;
    for (int k = 4; k < N_PE; k++) pe_vals[k] = 8'($urandom);
    issue_start();
    wait_done(accepted, 50, 0);

    // Reset during the third read cycle aborts the drain silently.
    issue_start();
    @(posedge clk); #1;
    @(posedge clk); #1;
    begin
      int d0;
      d0 = done_cnt;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("t4_pe_en", pe_en_out, 0);
      chk("t4_valid", out_valid, 0);
      chk("t4_busy", busy, 0);
      chk("t4_done", done, 0);
      chk("t4_no_done", done_cnt, d0);
    end
    q.delete();
    accepted--;
    for (int k = 0; k < N_PE; k++) pe_vals[k] = 8'($urandom);
    issue_start();
    wait_done(accepted, 50, 0);

    // Extra start mid-drain and start coincident with done are both ignored.
    issue_start();
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(accepted, 50, 0);
    chk("t5_done_cycle", done_cyc - start_cyc, 9);
    repeat (15) @(posedge clk);
    #1;
    chk("t5_done_count", done_cnt, accepted);
    chk("t5_busy", busy, 0);
    chk("t5_reads", rd_cycles, N_PE);

    // Random consumer backpressure over many drains.
    for (int d = 0; d < 100; d++) begin
      for (int k = 0; k < N_PE; k++) pe_vals[k] = 8'($urandom);
      issue_start();
      wait_done(accepted, 400, 1);
    end

    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("final_done_count", done_cnt, accepted);
    chk("final_queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
